mag_seq_ctrl: RTL and testbench

//  Sequencer that time-multiplexes one shared mag_est_single across an N-bin FFT frame.

---
 rtl/mag_seq_ctrl.sv | 125 ++++++++++++
 tb/tb_mag_seq_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mag_seq_ctrl.sv
// Frame sequencer sharing one magnitude estimator across all FFT bins.
// Streams per-bin magnitudes over valid/ready and tracks the frame peak.
module mag_seq_ctrl #(
  parameter int WIDTH  = 16,
  parameter int N      = 256,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_real,
  input  logic [WIDTH-1:0]  rd_imag,
  output logic [WIDTH-1:0]  est_real,
  output logic [WIDTH-1:0]  est_imag,
  input  logic [WIDTH:0]    est_mag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH:0]    out_mag,
  output logic [ADDR_W-1:0] out_bin,
  output logic [WIDTH:0]    peak_mag,
  output logic [ADDR_W-1:0] peak_bin
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    CALC,
    EMIT,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] INC  = ADDR_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      est_real  <= '0;
      est_imag  <= '0;
      out_valid <= 1'b0;
      out_mag   <= '0;
      out_bin   <= '0;
      peak_mag  <= '0;
      peak_bin  <= '0;
    end else if (abort) begin
      // in-flight beat is dropped; peak keeps partial result
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      done  <= 1'b0;
      rd_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            idx      <= '0;
            peak_mag <= '0;
            peak_bin <= '0;
            busy     <= 1'b1;
            rd_en    <= 1'b1;
            rd_addr  <= '0;
            state    <= FETCH;
          end
        end
        FETCH: begin
          state <= LATCH;
        end
        LATCH: begin
          est_real <= rd_real;
          est_imag <= rd_imag;
          state    <= CALC;
        end
        CALC: begin
          out_mag   <= est_mag;
          out_bin   <= idx;
          out_valid <= 1'b1;
          if (est_mag > peak_mag) begin
            peak_mag <= est_mag;
            peak_bin <= idx;
          end
          state <= EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (idx == LAST) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx     <= idx + INC;
              rd_en   <= 1'b1;
              rd_addr <= idx + INC;
              state   <= FETCH;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mag_seq_ctrl.sv
// Directed bench for mag_seq_ctrl: N=8 frames from a table,
// then backpressure, ignored start, abort and mid-frame reset.
module tb_mag_seq_ctrl;

  localparam int W  = 16;
  localparam int N  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_real = '0;
  logic [W-1:0]  rd_imag = '0;
  logic [W-1:0]  est_real;
  logic [W-1:0]  est_imag;
  logic [W:0]    est_mag;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W:0]    out_mag;
  logic [AW-1:0] out_bin;
  logic [W:0]    peak_mag;
  logic [AW-1:0] peak_bin;

  mag_seq_ctrl #(
    .WIDTH (W),
    .N     (N),
    .ADDR_W(AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_real  (rd_real),
    .rd_imag  (rd_imag),
    .est_real (est_real),
    .est_imag (est_imag),
    .est_mag  (est_mag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_mag  (out_mag),
    .out_bin  (out_bin),
    .peak_mag (peak_mag),
    .peak_bin (peak_bin)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem_re [N];
  logic [W-1:0] mem_im [N];

  always @(posedge clk) begin
    if (rd_en) begin
      rd_real <= mem_re[rd_addr];
      rd_imag <= mem_im[rd_addr];
    end
  end

  localparam logic [W:0] ONE = 1;

  function automatic logic [W:0] est_fn(logic [W-1:0] r, logic [W-1:0] i);
    logic [W:0] ar, ai, mx, mn;
    ar = r[W-1] ? (~{1'b1, r} + ONE) : {1'b0, r};
    ai = i[W-1] ? (~{1'b1, i} + ONE) : {1'b0, i};
    mx = (ar > ai) ? ar : ai;
    mn = (ar > ai) ? ai : ar;
    return mx + (mn >> 1);
  endfunction

  always_comb est_mag = est_fn(est_real, est_imag);

  typedef struct {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic [W:0]   mag;
  } vec_t;

  typedef struct {
    logic [W:0]    pk;
    logic [AW-1:0] pb;
  } frm_t;

  vec_t vecs [4*N];
  frm_t frms [4];

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(int f);
    for (int k = 0; k < N; k++) begin
      mem_re[k] = vecs[f*N+k].re;
      mem_im[k] = vecs[f*N+k].im;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_frame(int f, bit chk_cyc);
    int n;
    int beats;
    bit got;
    load(f);
    pulse_start();
    n = 1;
    beats = 0;
    got = 1'b0;
    while (n < 400 && !got) begin
      if (out_valid && out_ready) begin
        if (beats < N) begin
          chk($sformatf("f%0d mag bin%0d", f, beats),
              32'(out_mag), 32'(vecs[f*N+beats].mag));
          chk($sformatf("f%0d bin idx%0d", f, beats),
              32'(out_bin), 32'(beats));
        end
        beats++;
      end
      if (done) got = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk($sformatf("f%0d done seen", f), 32'(got), 32'd1);
    if (chk_cyc) chk("done cycle", 32'(n), 32'(4*N+1));
    chk($sformatf("f%0d beats", f), 32'(beats), 32'(N));
    chk($sformatf("f%0d peak_mag", f), 32'(peak_mag), 32'(frms[f].pk));
    chk($sformatf("f%0d peak_bin", f), 32'(peak_bin), 32'(frms[f].pb));
    @(negedge clk);
    chk($sformatf("f%0d done 1cyc", f), 32'(done), 32'd0);
    chk($sformatf("f%0d idle", f), 32'(busy), 32'd0);
  endtask

  localparam int MA [N] = '{0, 1, 3, 4, 6, 7, 9, 10};

  initial begin
    int n;
    int dn;
    int bz;
    bit inj;

    for (int k = 0; k < 4*N; k++) vecs[k] = '{'0, '0, '0};
    for (int k = 0; k < N; k++)
      vecs[k] = '{W'(k), W'(-k), 17'(MA[k])};
    vecs[N+3]   = '{16'd3, 16'hFFFC, 17'd5};
    vecs[2*N+2] = '{16'd100, 16'd100, 17'd150};
    vecs[2*N+5] = '{16'd100, 16'd100, 17'd150};
    vecs[3*N+0] = '{16'h8000, 16'h0000, 17'h08000};
    frms[0] = '{17'd10, 3'd7};
    frms[1] = '{17'd5, 3'd3};
    frms[2] = '{17'd150, 3'd2};
    frms[3] = '{17'h08000, 3'd0};

    repeat (2) @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst rd_en", 32'(rd_en), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_mag", 32'(out_mag), 32'd0);
    chk("rst peak_mag", 32'(peak_mag), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_frame(0, 1'b1);
    for (int f = 1; f < 4; f++) run_frame(f, 1'b0);

    // backpressure on bin 4
    load(0);
    pulse_start();
    for (int i = 0; i < 100 && !(rd_en && rd_addr == 3'd4); i++)
      @(negedge clk);
    chk("bp fetch4", 32'(rd_en && rd_addr == 3'd4), 32'd1);
    out_ready = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp valid c%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp mag c%0d", i), 32'(out_mag), 32'd6);
      chk($sformatf("bp bin c%0d", i), 32'(out_bin), 32'd4);
      chk($sformatf("bp rd_en c%0d", i), 32'(rd_en), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp accept valid", 32'(out_valid), 32'd0);
    chk("bp next fetch", 32'({rd_en, rd_addr}), 32'({1'b1, 3'd5}));
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    chk("bp done", 32'(done), 32'd1);
    chk("bp peak_mag", 32'(peak_mag), 32'd10);
    chk("bp peak_bin", 32'(peak_bin), 32'd7);
    @(negedge clk);

    // start pulses mid-frame and on the done cycle are ignored
    load(0);
    pulse_start();
    n = 1;
    inj = 1'b0;
    for (; n < 200 && !done; n++) begin
      if (rd_en && rd_addr == 3'd3 && !inj) begin
        start = 1'b1;
        inj = 1'b1;
      end else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk("ign done cycle", 32'(n), 32'(4*N+1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign busy after done", 32'(busy), 32'd0);
    dn = 0;
    bz = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) dn++;
      if (busy) bz++;
    end
    chk("ign extra done", 32'(dn), 32'd0);
    chk("ign extra busy", 32'(bz), 32'd0);

    // abort in LATCH of bin 2
    load(0);
    pulse_start();
    for (int i = 0; i < 100 && !(rd_en && rd_addr == 3'd2); i++)
      @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort valid", 32'(out_valid), 32'd0);
    chk("abort rd_en", 32'(rd_en), 32'd0);
    chk("abort peak_mag", 32'(peak_mag), 32'd1);
    chk("abort peak_bin", 32'(peak_bin), 32'd1);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    chk("abort quiet", 32'(dn), 32'd0);

    // reset during EMIT of a new frame
    pulse_start();
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    chk("rst2 in emit", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst2 busy", 32'(busy), 32'd0);
    chk("rst2 done", 32'(done), 32'd0);
    chk("rst2 rd", 32'({rd_en, rd_addr}), 32'd0);
    chk("rst2 est", 32'({est_real, est_imag}), 32'd0);
    chk("rst2 valid", 32'(out_valid), 32'd0);
    chk("rst2 out", 32'({out_mag, out_bin}), 32'd0);
    chk("rst2 peak", 32'({peak_mag, peak_bin}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    chk("rst2 quiet", 32'(dn), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
